spi_slave_if_rtl: RTL and testbench
===================================

SPI_SLAVE_IF_RTL -- requirements
Module: spi_slave_if_rtl

Interface
REQ-001 Parameter BITS, default 28: length of one SPI word in bits.
REQ-002 i_clk  in  1  system clock; all logic is on the rising edge.
REQ-003 i_rst  in  1  asynchronous, active-low reset.
REQ-004 i_sclk  in  1  SPI serial clock from the master; asynchronous to i_clk.
REQ-005 i_mosi  in  1  SPI data from the master.
REQ-006 i_ss  in  1  SPI slave select, active-low.
REQ-007 o_miso  out  1  SPI data to the master.
REQ-008 i_data  in  BITS  word to transmit in the next transfer.
REQ-009 i_load  in  1  one-cycle strobe that captures i_data into the TX buffer.
REQ-010 o_data  out  BITS  last complete received word.
REQ-011 o_valid  out  1  one-cycle pulse when o_data is updated.
REQ-012 o_busy  out  1  high while a transfer is in progress.
REQ-013 o_abort  out  1  one-cycle pulse when a transfer ends early.

Function
REQ-014 i_sclk, i_mosi and i_ss SHALL each pass through a 2-flop synchronizer; edges SHALL be detected on the synchronized copies.
REQ-015 SPI mode SHALL be 0 (CPOL=0, CPHA=0), MSB first.
REQ-016 The master SHALL hold i_sclk high and low for at least 4 i_clk cycles each; the block SHALL be specified only under this constraint.
REQ-017 The FSM SHALL have states IDLE, SHIFT and DONE.
REQ-018 IDLE -> SHIFT on a synchronized i_ss falling edge: TX shift register <= TX buffer, bit counter <= 0, o_busy <= 1.
REQ-019 On entry to SHIFT, o_miso SHALL present TX bit BITS-1 before the first i_sclk rising edge.
REQ-020 In SHIFT, on each synchronized i_sclk rising edge: RX shift register <= {rx[BITS-2:0], mosi_sync}, counter <= counter+1.
REQ-021 In SHIFT, on each synchronized i_sclk falling edge with counter < BITS: TX shift left by one, and o_miso drives the new MSB.
REQ-022 When the counter reaches BITS: SHIFT -> DONE, o_data <= RX register, o_valid = 1 for exactly one cycle.
REQ-023 In DONE, further i_sclk edges SHALL be ignored and o_miso SHALL be 0.
REQ-024 DONE -> IDLE on i_ss rising edge: o_busy <= 0.
REQ-025 i_ss rising while in SHIFT (counter < BITS): -> IDLE, o_abort pulses for one cycle, o_data unchanged, no o_valid.
REQ-026 i_load SHALL update the TX buffer in any state; the update affects only the next transfer, never the word being shifted.
REQ-027 If i_load coincides with the i_ss falling edge detection, the TX shift register SHALL take i_data directly (bypass).
REQ-028 o_miso SHALL be 0 in IDLE; there is no tristate.
REQ-029 The bit counter SHALL be $clog2(BITS+1) wide and SHALL never wrap.
REQ-030 Worst-case latency from the last i_sclk rising edge to o_valid SHALL be 4 i_clk cycles.

Reset
REQ-031 While i_rst=0: state IDLE; o_data, TX buffer, shift registers and counter = 0; o_valid, o_abort, o_busy, o_miso = 0; synchronizers = i_ss high, i_sclk low.
REQ-032 Reset asserted mid-transfer SHALL discard the partial word with no o_valid or o_abort; after release the block SHALL wait for a fresh i_ss falling edge.

Verification
REQ-033 Full-duplex transfer: i_load with 28'h0ABCDEF; master sends 28'h5A5A5A5 -> o_data=28'h5A5A5A5 with a single o_valid pulse; master receives 28'h0ABCDEF.
REQ-034 Back-to-back transfers: words 28'h0000001 then 28'hFFFFFFF with i_ss high for 2 SCLK periods between them -> two o_valid pulses with the correct values; o_busy drops between the transfers.
REQ-035 Early abort: i_ss goes high after 13 SCLK -> o_abort=1 for one cycle; o_data keeps its previous value; o_valid stays 0.
REQ-036 i_load of 28'h1234567 mid-transfer -> the current TX word is unchanged; the next transfer returns 28'h1234567.
REQ-037 30 SCLK pulses in one i_ss frame -> o_valid once after pulse 28; o_miso=0 for pulses 29-30.
REQ-038 i_rst pulled low after 10 bits, then released -> all outputs 0; the next full transfer of 28'h0F0F0F0 is received correctly.

Source files
------------

// File: rtl/spi_slave_if_rtl.sv
`default_nettype none
// ============================================================================
// Module      : spi_slave_if_rtl
// Description : SPI mode-0 slave, MSB first, full duplex, one BITS-wide word
//               per slave-select frame. SCLK/MOSI/SS are oversampled by clk
//               through 2-flop synchronizers. TX word is double-buffered;
//               early SS release aborts the frame.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_slave_if_rtl #(
  parameter int BITS = 28
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_sclk,
  input  logic            i_mosi,
  input  logic            i_ss,
  output logic            o_miso,
  input  logic [BITS-1:0] i_data,
  input  logic            i_load,
  output logic [BITS-1:0] o_data,
  output logic            o_valid,
  output logic            o_busy,
  output logic            o_abort
);

  localparam int              c_CW    = $clog2(BITS + 1);
  localparam logic [c_CW-1:0] c_LAST  = c_CW'(BITS - 1);
  localparam logic [c_CW-1:0] c_FULL  = c_CW'(BITS);

  localparam logic [1:0]      c_IDLE  = 2'd0;
  localparam logic [1:0]      c_SHIFT = 2'd1;
  localparam logic [1:0]      c_DONE  = 2'd2;

  logic            r_sclk_s1, r_sclk_s2, r_sclk_d;
  logic            r_ss_s1, r_ss_s2, r_ss_d;
  logic            r_mosi_s1, r_mosi_s2;
  logic [1:0]      r_state;
  logic [1:0]      w_state_next;
  logic [BITS-1:0] r_tx_buf;
  logic [BITS-1:0] r_tx_sh;
  logic [BITS-1:0] r_rx_sh;
  logic [c_CW-1:0] r_cnt;
  logic            r_cap;
  logic [BITS-1:0] r_data;
  logic            r_valid;
  logic            r_busy;
  logic            r_abort;
  logic            w_sclk_rise, w_sclk_fall, w_ss_fall, w_ss_rise;

  // Two-flop synchronizers plus one delay stage for edge detection; the
  // reset values model an idle bus (SS deasserted, SCLK low).
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_sclk_s1 <= 1'b0;
      r_sclk_s2 <= 1'b0;
      r_sclk_d  <= 1'b0;
      r_ss_s1   <= 1'b1;
      r_ss_s2   <= 1'b1;
      r_ss_d    <= 1'b1;
      r_mosi_s1 <= 1'b0;
      r_mosi_s2 <= 1'b0;
    end else begin
      r_sclk_s1 <= i_sclk;
      r_sclk_s2 <= r_sclk_s1;
      r_sclk_d  <= r_sclk_s2;
      r_ss_s1   <= i_ss;
      r_ss_s2   <= r_ss_s1;
      r_ss_d    <= r_ss_s2;
      r_mosi_s1 <= i_mosi;
      r_mosi_s2 <= r_mosi_s1;
    end
  end

  assign w_sclk_rise =  r_sclk_s2 & ~r_sclk_d;
  assign w_sclk_fall = ~r_sclk_s2 &  r_sclk_d;
  assign w_ss_fall   = ~r_ss_s2   &  r_ss_d;
  assign w_ss_rise   =  r_ss_s2   & ~r_ss_d;

  // State register.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; SS release has priority over a coincident last edge.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_IDLE:  if (w_ss_fall) w_state_next = c_SHIFT;
      c_SHIFT: begin
        if (w_ss_rise) begin
          w_state_next = c_IDLE;
        end else if (w_sclk_rise && (r_cnt == c_LAST)) begin
          w_state_next = c_DONE;
        end
      end
      c_DONE:  if (w_ss_rise) w_state_next = c_IDLE;
      default: w_state_next = c_IDLE;
    endcase
  end

  // Datapath: TX buffer, shift registers, bit counter and status strobes.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_tx_buf <= '0;
      r_tx_sh  <= '0;
      r_rx_sh  <= '0;
      r_cnt    <= '0;
      r_cap    <= 1'b0;
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
      r_abort  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_abort <= 1'b0;
      r_cap   <= 1'b0;
      if (i_load) begin
        r_tx_buf <= i_data;
      end
      // Publish the received word one cycle after the final bit lands.
      if (r_cap) begin
        r_data  <= r_rx_sh;
        r_valid <= 1'b1;
      end
      case (r_state)
        c_IDLE: begin
          if (w_ss_fall) begin
            // A load on this very cycle bypasses the buffer.
            r_tx_sh <= i_load ? i_data : r_tx_buf;
            r_rx_sh <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        c_SHIFT: begin
          if (w_ss_rise) begin
            r_busy  <= 1'b0;
            r_abort <= 1'b1;
          end else if (w_sclk_rise) begin
            r_rx_sh <= {r_rx_sh[BITS-2:0], r_mosi_s2};
            r_cnt   <= r_cnt + 1'b1;
            if (r_cnt == c_LAST) begin
              r_cap <= 1'b1;
            end
          end else if (w_sclk_fall && (r_cnt < c_FULL)) begin
            r_tx_sh <= {r_tx_sh[BITS-2:0], 1'b0};
          end
        end
        c_DONE: begin
          if (w_ss_rise) begin
            r_busy <= 1'b0;
          end
        end
        default: begin
          r_busy <= 1'b0;
        end
      endcase
    end
  end

  // MISO carries the TX MSB only while shifting; it is driven low otherwise.
  always_comb begin
    o_miso = 1'b0;
    if (r_state == c_SHIFT) begin
      o_miso = r_tx_sh[BITS-1];
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;
  assign o_busy  = r_busy;
  assign o_abort = r_abort;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_if_rtl.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_slave_if_rtl
// Description : Self-checking bench for spi_slave_if_rtl; acts as SPI master
//               and compares against a word-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_slave_if_rtl;

  localparam int BITS = 28;
  localparam int H    = 6;   // SCLK half period in clk cycles

  logic            clk = 1'b0;
  logic            rst_n;
  logic            sclk, mosi, ss, miso, load, valid, busy, abort;
  logic [BITS-1:0] din, dout;

  int checks = 0;
  int passed = 0;
  int valid_cnt = 0, abort_cnt = 0, wide_valid = 0, wide_abort = 0;
  logic prev_v = 1'b0, prev_a = 1'b0;

  // Reference model state: the TX buffer and last published word.
  logic [BITS-1:0] m_txbuf = '0;
  logic [BITS-1:0] m_odata = '0;

  spi_slave_if_rtl #(.BITS(BITS)) dut (
    .i_clk  (clk),
    .i_rst  (rst_n),
    .i_sclk (sclk),
    .i_mosi (mosi),
    .i_ss   (ss),
    .o_miso (miso),
    .i_data (din),
    .i_load (load),
    .o_data (dout),
    .o_valid(valid),
    .o_busy (busy),
    .o_abort(abort)
  );

  always #5 clk = ~clk;

  // Pulse monitor: counts strobes and strobes wider than one cycle.
  always @(negedge clk) begin
    if (valid) valid_cnt <= valid_cnt + 1;
    if (abort) abort_cnt <= abort_cnt + 1;
    if (valid && prev_v) wide_valid <= wide_valid + 1;
    if (abort && prev_a) wide_abort <= wide_abort + 1;
    prev_v <= valid;
    prev_a <= abort;
  end

  task automatic sclk_pulse(input logic b, output logic m);
    mosi = b;
    repeat (H) @(negedge clk);
    m = miso;
    sclk = 1'b1;
    repeat (H) @(negedge clk);
    sclk = 1'b0;
  endtask

  task automatic do_pulses(input logic [BITS-1:0] w, input int from, input int to,
                           inout logic [BITS-1:0] got);
    logic b;
    for (int i = from; i < to; i++) begin
      sclk_pulse(w[BITS-1-i], b);
      got[BITS-1-i] = b;
    end
  endtask

  task automatic ss_begin();
    ss = 1'b0;
    repeat (H) @(negedge clk);
  endtask

  task automatic ss_end();
    repeat (H) @(negedge clk);
    ss = 1'b1;
    repeat (2*H) @(negedge clk);
  endtask

  task automatic do_load(input logic [BITS-1:0] w);
    @(negedge clk);
    din = w; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    m_txbuf = w;
  endtask

  task automatic do_xfer(input logic [BITS-1:0] w, output logic [BITS-1:0] got);
    logic [BITS-1:0] g = '0;
    ss_begin();
    do_pulses(w, 0, BITS, g);
    ss_end();
    got = g;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ss = 1'b1; sclk = 1'b0; mosi = 1'b0; load = 1'b0; din = '0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (dout !== '0) $display("FAIL reset_data: got %h expected 0", dout); else passed++;
    checks++;
    if ({valid, busy, abort, miso} !== 4'b0)
      $display("FAIL reset_flags: got %b expected 0000", {valid, busy, abort, miso});
    else passed++;
  endtask

  task automatic test_full_duplex();
    logic [BITS-1:0] w = 28'h5A5A5A5;
    logic [BITS-1:0] got = '0;
    int v0;
    do_load(28'h0ABCDEF);
    v0 = valid_cnt;
    ss_begin();
    do_pulses(w, 0, 14, got);
    checks++;
    if (busy !== 1'b1) $display("FAIL fd_busy_mid: got %b expected 1", busy); else passed++;
    do_pulses(w, 14, BITS, got);
    ss_end();
    m_odata = w;
    checks++;
    if (dout !== m_odata) $display("FAIL fd_rx: got %h expected %h", dout, m_odata); else passed++;
    checks++;
    if (got !== 28'h0ABCDEF) $display("FAIL fd_tx: got %h expected 0abcdef", got); else passed++;
    checks++;
    if (valid_cnt - v0 !== 1) $display("FAIL fd_valid_cnt: got %0d expected 1", valid_cnt - v0); else passed++;
    checks++;
    if (busy !== 1'b0) $display("FAIL fd_busy_end: got %b expected 0", busy); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [BITS-1:0] got = '0;
    int v0 = valid_cnt;
    ss_begin();
    do_pulses(28'h0000001, 0, BITS, got);
    repeat (H) @(negedge clk);
    ss = 1'b1;
    repeat (2*H) @(negedge clk);
    m_odata = 28'h0000001;
    checks++;
    if (busy !== 1'b0) $display("FAIL b2b_busy_gap: got %b expected 0", busy); else passed++;
    checks++;
    if (dout !== m_odata) $display("FAIL b2b_rx1: got %h expected %h", dout, m_odata); else passed++;
    checks++;
    if (got !== m_txbuf) $display("FAIL b2b_tx1: got %h expected %h", got, m_txbuf); else passed++;
    repeat (2*H) @(negedge clk);
    do_xfer(28'hFFFFFFF, got);
    m_odata = 28'hFFFFFFF;
    checks++;
    if (dout !== m_odata) $display("FAIL b2b_rx2: got %h expected %h", dout, m_odata); else passed++;
    checks++;
    if (valid_cnt - v0 !== 2) $display("FAIL b2b_valid_cnt: got %0d expected 2", valid_cnt - v0); else passed++;
  endtask

  task automatic test_abort();
    logic [BITS-1:0] got = '0;
    logic [BITS-1:0] w = BITS'($urandom);
    int v0 = valid_cnt;
    int a0 = abort_cnt;
    ss_begin();
    do_pulses(w, 0, 13, got);
    ss_end();
    checks++;
    if (abort_cnt - a0 !== 1) $display("FAIL abort_cnt: got %0d expected 1", abort_cnt - a0); else passed++;
    checks++;
    if (wide_abort !== 0) $display("FAIL abort_width: got %0d wide expected 0", wide_abort); else passed++;
    checks++;
    if (dout !== m_odata) $display("FAIL abort_data: got %h expected %h", dout, m_odata); else passed++;
    checks++;
    if (valid_cnt - v0 !== 0) $display("FAIL abort_valid: got %0d expected 0", valid_cnt - v0); else passed++;
  endtask

  task automatic test_load_mid();
    logic [BITS-1:0] cur = BITS'($urandom);
    logic [BITS-1:0] w = BITS'($urandom);
    logic [BITS-1:0] got = '0;
    do_load(cur);
    ss_begin();
    do_pulses(w, 0, 10, got);
    do_load(28'h1234567);
    do_pulses(w, 10, BITS, got);
    ss_end();
    m_odata = w;
    checks++;
    if (got !== cur) $display("FAIL loadmid_cur: got %h expected %h", got, cur); else passed++;
    w = BITS'($urandom);
    do_xfer(w, got);
    m_odata = w;
    checks++;
    if (got !== m_txbuf) $display("FAIL loadmid_next: got %h expected %h", got, m_txbuf); else passed++;
    checks++;
    if (dout !== m_odata) $display("FAIL loadmid_rx: got %h expected %h", dout, m_odata); else passed++;
  endtask

  task automatic test_overclock();
    logic [BITS-1:0] w = BITS'($urandom);
    logic [BITS-1:0] got = '0;
    logic m;
    int v0 = valid_cnt;
    int a0 = abort_cnt;
    ss_begin();
    do_pulses(w, 0, BITS, got);
    m_odata = w;
    checks++;
    if (valid_cnt - v0 !== 1) $display("FAIL over_valid28: got %0d expected 1", valid_cnt - v0); else passed++;
    for (int p = 0; p < 2; p++) begin
      sclk_pulse(1'b1, m);
      checks++;
      if (m !== 1'b0) $display("FAIL over_miso%0d: got %b expected 0", 29 + p, m); else passed++;
    end
    ss_end();
    checks++;
    if (valid_cnt - v0 !== 1 || abort_cnt != a0)
      $display("FAIL over_strobes: got valid %0d abort %0d expected 1 0", valid_cnt - v0, abort_cnt - a0);
    else passed++;
    checks++;
    if (dout !== m_odata) $display("FAIL over_rx: got %h expected %h", dout, m_odata); else passed++;
  endtask

  task automatic test_reset_mid();
    logic [BITS-1:0] got = '0;
    int v0 = valid_cnt;
    int a0 = abort_cnt;
    ss_begin();
    do_pulses(BITS'($urandom), 0, 10, got);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    ss = 1'b1; sclk = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    m_txbuf = '0;
    m_odata = '0;
    repeat (4) @(negedge clk);
    checks++;
    if ({dout, valid, busy, abort, miso} !== '0)
      $display("FAIL rstmid_outputs: got %h/%b expected all 0", dout, {valid, busy, abort, miso});
    else passed++;
    checks++;
    if (valid_cnt != v0 || abort_cnt != a0)
      $display("FAIL rstmid_strobes: got valid %0d abort %0d expected 0 0", valid_cnt - v0, abort_cnt - a0);
    else passed++;
    do_xfer(28'h0F0F0F0, got);
    m_odata = 28'h0F0F0F0;
    checks++;
    if (dout !== m_odata) $display("FAIL rstmid_rx: got %h expected %h", dout, m_odata); else passed++;
    checks++;
    if (got !== m_txbuf) $display("FAIL rstmid_tx: got %h expected %h", got, m_txbuf); else passed++;
  endtask

  task automatic test_bypass();
    logic [BITS-1:0] w = BITS'($urandom);
    logic [BITS-1:0] rxw = BITS'($urandom);
    logic [BITS-1:0] got = '0;
    ss = 1'b0;
    @(negedge clk);
    @(negedge clk);
    din = w; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    m_txbuf = w;
    repeat (H) @(negedge clk);
    do_pulses(rxw, 0, BITS, got);
    ss_end();
    m_odata = rxw;
    checks++;
    if (got !== w) $display("FAIL bypass_tx: got %h expected %h", got, w); else passed++;
  endtask

  task automatic test_random();
    logic [BITS-1:0] tx, rx, got;
    int v0;
    for (int i = 0; i < 4; i++) begin
      if ($urandom_range(0, 3) != 0) begin
        tx = BITS'($urandom);
        do_load(tx);
      end
      rx = BITS'($urandom);
      v0 = valid_cnt;
      do_xfer(rx, got);
      m_odata = rx;
      checks++;
      if (dout !== m_odata) $display("FAIL rand_rx%0d: got %h expected %h", i, dout, m_odata); else passed++;
      checks++;
      if (got !== m_txbuf) $display("FAIL rand_tx%0d: got %h expected %h", i, got, m_txbuf); else passed++;
      checks++;
      if (valid_cnt - v0 !== 1 || wide_valid !== 0)
        $display("FAIL rand_valid%0d: got %0d pulses (%0d wide) expected 1", i, valid_cnt - v0, wide_valid);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_full_duplex();
    test_back_to_back();
    test_abort();
    test_load_mid();
    test_overclock();
    test_reset_mid();
    test_bypass();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
